// File: rtl/usb1_ep0_pkg.sv
// Shared definitions for the endpoint-0 packet buffer.
package usb1_ep0_pkg;

   // Bit positions inside ep0_stat
   localparam int EP0_ST_OUT_AV  = 0;
   localparam int EP0_ST_IN_FULL = 1;
   localparam int EP0_ST_SETUP   = 2;
   localparam int EP0_ST_OVF     = 3;

   // Per-direction transaction state
   typedef enum logic {
      TXN_IDLE   = 1'b0,
      TXN_ACTIVE = 1'b1
   } txn_state_t;

endpackage

// File: rtl/usb1_txn_fifo.sv
// Byte FIFO with one speculative pointer and a commit/rollback pointer.
// SPEC_ON_WRITE=1: writes are speculative until commit (OUT direction).
// SPEC_ON_WRITE=0: reads are speculative until commit (IN direction).
// Handshake: a request (i_wr/i_rd) is honoured in the cycle it is high if the
// FIFO can accept/supply it; otherwise it is dropped. Data is first-word-fall-
// through and reflects the pointers registered at the previous edge.
module usb1_txn_fifo
   import usb1_ep0_pkg::*;
#(
   parameter int AW            = 4,
   parameter bit SPEC_ON_WRITE = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr,
   input  logic [7:0]    i_wdata,
   input  logic          i_rd,
   output logic [7:0]    o_rdata,
   input  logic          i_commit,
   input  logic          i_rollback,
   input  logic          i_tag,
   input  logic          i_flush,
   output logic [AW:0]   o_count,
   output logic          o_wr_drop,
   output logic          o_tag
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [7:0]  r_mem [2**AW];
   logic [AW:0] r_wr, r_rd, r_comm;
   logic [AW:0] w_wr_nxt, w_rd_nxt, w_comm_nxt;
   txn_state_t  r_state, w_state_nxt;
   logic        r_tag;
   logic        w_full, w_avail, w_req, w_active;
   logic        w_do_wr, w_do_rd, w_rollback, w_commit, w_avail_nxt;

   // Request qualification; the commit pointer bounds whichever side is speculative
   always_comb begin
      w_full     = SPEC_ON_WRITE ? ((r_wr - r_rd) == DEPTH) : ((r_wr - r_comm) == DEPTH);
      w_avail    = SPEC_ON_WRITE ? (r_comm != r_rd) : (r_wr != r_rd);
      w_req      = (SPEC_ON_WRITE ? i_wr : i_rd) & ~i_flush;
      // A request in the same cycle as commit/rollback makes the transaction live
      w_active   = (r_state == TXN_ACTIVE) | w_req;
      w_do_wr    = i_wr & ~w_full & ~i_flush;
      w_do_rd    = i_rd & w_avail & ~i_flush;
      w_rollback = i_rollback & w_active & ~i_flush;
      w_commit   = i_commit & ~i_rollback & w_active & ~i_flush;
      o_wr_drop  = i_wr & w_full & ~i_flush;
   end

   // Next pointer values: flush > rollback > commit > plain advance
   always_comb begin
      w_wr_nxt   = r_wr + {{AW{1'b0}}, w_do_wr};
      w_rd_nxt   = r_rd + {{AW{1'b0}}, w_do_rd};
      w_comm_nxt = r_comm;
      if (i_flush) begin
         w_wr_nxt = r_comm;
         w_rd_nxt = r_comm;
      end else if (SPEC_ON_WRITE) begin
         if (w_rollback)    w_wr_nxt   = r_comm;
         else if (w_commit) w_comm_nxt = w_wr_nxt;
      end else begin
         if (w_rollback)    w_rd_nxt   = r_comm;
         else if (w_commit) w_comm_nxt = w_rd_nxt;
      end
      w_avail_nxt = SPEC_ON_WRITE ? (w_comm_nxt != w_rd_nxt) : (w_wr_nxt != w_rd_nxt);
   end

   // Transaction FSM next state
   always_comb begin
      w_state_nxt = r_state;
      if (i_flush || w_rollback) w_state_nxt = TXN_IDLE;
      else if (w_commit)         w_state_nxt = w_req ? TXN_ACTIVE : TXN_IDLE;
      else if (w_req)            w_state_nxt = TXN_ACTIVE;
   end

   // Transaction FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= TXN_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Pointer and tag registers; the tag marks the committed packet until it is drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_comm <= '0;
         r_tag  <= 1'b0;
      end else begin
         r_wr   <= w_wr_nxt;
         r_rd   <= w_rd_nxt;
         r_comm <= w_comm_nxt;
         if (i_flush)                       r_tag <= 1'b0;
         else if (w_commit && i_tag)        r_tag <= 1'b1;
         else if (w_do_rd && !w_avail_nxt)  r_tag <= 1'b0;
      end
   end

   // Storage array (not reset)
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd[AW-1:0]];
   assign o_count = SPEC_ON_WRITE ? (r_comm - r_rd) : (r_wr - r_comm);
   assign o_tag   = r_tag;

endmodule

// File: rtl/usb1_ep0_buf.sv
// Endpoint-0 packet buffer: OUT/SETUP FIFO (commit on good CRC) and
// IN FIFO (release on host ACK) between the protocol engine and usb1_ctrl.
module usb1_ep0_buf
   import usb1_ep0_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pe_we,
   input  logic [7:0]    pe_din,
   input  logic          pe_setup,
   input  logic          pe_commit,
   input  logic          pe_abort,
   input  logic          pe_re,
   output logic [7:0]    pe_dout,
   input  logic          pe_ack,
   input  logic          pe_nak,
   output logic [AW:0]   pe_in_cnt,
   input  logic          ep0_re,
   output logic [7:0]    ep0_din,
   input  logic          ep0_we,
   input  logic [7:0]    ep0_dout,
   output logic [3:0]    ep0_stat,
   input  logic          ctrl_setup
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [AW:0] w_out_cnt;
   logic        w_out_drop, w_in_drop;
   logic        w_out_tag, w_in_tag;
   logic        r_ovf;

   usb1_txn_fifo #(.AW(AW), .SPEC_ON_WRITE(1'b1)) u_out (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (pe_we),
      .i_wdata    (pe_din),
      .i_rd       (ep0_re),
      .o_rdata    (ep0_din),
      .i_commit   (pe_commit),
      .i_rollback (pe_abort),
      .i_tag      (pe_setup),
      .i_flush    (1'b0),
      .o_count    (w_out_cnt),
      .o_wr_drop  (w_out_drop),
      .o_tag      (w_out_tag)
   );

   usb1_txn_fifo #(.AW(AW), .SPEC_ON_WRITE(1'b0)) u_in (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (ep0_we),
      .i_wdata    (ep0_dout),
      .i_rd       (pe_re),
      .o_rdata    (pe_dout),
      .i_commit   (pe_ack),
      .i_rollback (pe_nak),
      .i_tag      (1'b0),
      .i_flush    (ctrl_setup),
      .o_count    (pe_in_cnt),
      .o_wr_drop  (w_in_drop),
      .o_tag      (w_in_tag)
   );

   // Sticky overflow; a SETUP clears it unless an OUT byte is dropped in that same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_ovf <= 1'b0;
      else if (ctrl_setup)              r_ovf <= w_out_drop;
      else if (w_out_drop || w_in_drop) r_ovf <= 1'b1;
   end

   // Status word; the IN tag input is tied low so only the OUT tag can raise SETUP
   always_comb begin
      ep0_stat                 = '0;
      ep0_stat[EP0_ST_OUT_AV]  = (w_out_cnt != '0);
      ep0_stat[EP0_ST_IN_FULL] = (pe_in_cnt == DEPTH);
      ep0_stat[EP0_ST_SETUP]   = w_out_tag | w_in_tag;
      ep0_stat[EP0_ST_OVF]     = r_ovf;
   end

endmodule
